// File: rtl/set_assoc_dcache_if.sv
// CPU-side and memory-side bus bundles for set_assoc_dcache.
// Handshake: the requester raises read/write with stable address and data and holds them until busywait/mem_busywait is 0; the transfer completes in that cycle.
interface set_assoc_dcache_cpu_if #(
  parameter int ADDR_W = 32
);
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic              busywait;

  modport master (output read, write, address, writedata, input readdata, busywait);
  modport slave  (input read, write, address, writedata, output readdata, busywait);
endinterface

interface set_assoc_dcache_mem_if #(
  parameter int MA_W  = 28,
  parameter int BLK_W = 128
);
  logic             mem_read;
  logic             mem_write;
  logic [MA_W-1:0]  mem_address;
  logic [BLK_W-1:0] mem_writedata;
  logic [BLK_W-1:0] mem_readdata;
  logic             mem_busywait;

  modport master (output mem_read, mem_write, mem_address, mem_writedata,
                  input mem_readdata, mem_busywait);
  modport slave  (input mem_read, mem_write, mem_address, mem_writedata,
                  output mem_readdata, mem_busywait);
endinterface

// File: rtl/set_assoc_dcache.sv
// Write-back, write-allocate N-way set-associative data cache with LRU replacement.
// Optional hit/miss/write-back counters are enabled by defining DCACHE_STATS_EN.
module set_assoc_dcache #(
  parameter int ADDR_W = 32,
  parameter int WAYS   = 2,
  parameter int SETS   = 8,
  parameter int WORDS  = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  set_assoc_dcache_cpu_if.slave  cpu,
  set_assoc_dcache_mem_if.master mem,
  output logic [1:0]             dbg_state
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]            hit_count,
  output logic [31:0]            miss_count,
  output logic [31:0]            wb_count
`endif
);
  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - 2 - OFF_W - IDX_W;
  localparam int BLK_W = 32 * WORDS;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, WRITEBACK = 2'd1, ALLOCATE = 2'd2} state_t;
  state_t state, state_nxt;

  logic [BLK_W-1:0] data_arr [WAYS][SETS];
  logic [TAG_W-1:0] tag_arr  [WAYS][SETS];
  logic             valid_q  [WAYS][SETS];
  logic             dirty_q  [WAYS][SETS];
  logic [WAY_W-1:0] age_q    [WAYS][SETS];

  logic [OFF_W-1:0] off;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             unused_addr_lsb;

  assign off = cpu.address[OFF_W+1:2];
  assign idx = cpu.address[OFF_W+IDX_W+1:OFF_W+2];
  assign tag = cpu.address[ADDR_W-1 -: TAG_W];
  assign unused_addr_lsb = ^cpu.address[1:0];

  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] vic_way;
  logic [WAY_W-1:0] vic_q;
  logic [IDX_W-1:0] idx_q;
  logic [TAG_W-1:0] miss_tag_q;
  logic             req, hit_acc, miss_start, fill, wb_done, acc_en;
  logic [WAY_W-1:0] acc_way;
  logic [IDX_W-1:0] acc_idx;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[w][idx] && tag_arr[w][idx] == tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Ages are a permutation, so the LRU way is the one holding age WAYS-1; invalid ways take priority.
  always_comb begin
    vic_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (age_q[w][idx] == WAY_W'(WAYS - 1)) vic_way = WAY_W'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[w][idx]) vic_way = WAY_W'(w);
    end
  end

  assign req        = cpu.read | cpu.write;
  assign hit_acc    = (state == IDLE) && req && hit;
  assign miss_start = (state == IDLE) && req && !hit;
  assign fill       = (state == ALLOCATE) && !mem.mem_busywait;
  assign wb_done    = (state == WRITEBACK) && !mem.mem_busywait;
  assign acc_en     = hit_acc | fill;
  assign acc_way    = fill ? vic_q : hit_way;
  assign acc_idx    = fill ? idx_q : idx;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (miss_start) state_nxt = dirty_q[vic_way][idx] ? WRITEBACK : ALLOCATE;
      WRITEBACK: if (!mem.mem_busywait) state_nxt = ALLOCATE;
      ALLOCATE:  if (!mem.mem_busywait) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem.mem_read      = (state == ALLOCATE);
    mem.mem_write     = (state == WRITEBACK);
    mem.mem_address   = (state == WRITEBACK) ? {tag_arr[vic_q][idx_q], idx_q} : {miss_tag_q, idx_q};
    mem.mem_writedata = data_arr[vic_q][idx_q];
    cpu.busywait      = reset && req && !((state == IDLE) && hit);
    cpu.readdata      = (reset && hit) ? data_arr[hit_way][idx][{off, 5'b0} +: 32] : 32'd0;
    dbg_state         = state;
  end

  // Victim, index and missing tag are latched so a dropped request still fills the right line.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vic_q      <= '0;
      idx_q      <= '0;
      miss_tag_q <= '0;
    end else if (miss_start) begin
      vic_q      <= vic_way;
      idx_q      <= idx;
      miss_tag_q <= tag;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int w = 0; w < WAYS; w++) begin
        for (int s = 0; s < SETS; s++) begin
          valid_q[w][s] <= 1'b0;
          dirty_q[w][s] <= 1'b0;
          age_q[w][s]   <= WAY_W'(w);
        end
      end
    end else begin
      if (fill) begin
        valid_q[vic_q][idx_q] <= 1'b1;
        dirty_q[vic_q][idx_q] <= 1'b0;
      end
      if (hit_acc && cpu.write) dirty_q[hit_way][idx] <= 1'b1;
      if (acc_en && WAYS > 1) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == acc_way)
            age_q[w][acc_idx] <= '0;
          else if (age_q[w][acc_idx] < age_q[acc_way][acc_idx])
            age_q[w][acc_idx] <= age_q[w][acc_idx] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (fill) begin
      data_arr[vic_q][idx_q] <= mem.mem_readdata;
      tag_arr[vic_q][idx_q]  <= miss_tag_q;
    end
    if (hit_acc && cpu.write) data_arr[hit_way][idx][{off, 5'b0} +: 32] <= cpu.writedata;
  end

`ifdef DCACHE_STATS_EN
  // The hit that completes a miss is not counted; pending marks that a miss is still being served.
  logic pending_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
      pending_q  <= 1'b0;
    end else begin
      if (miss_start) pending_q <= 1'b1;
      else if (state == IDLE && (hit_acc || !req)) pending_q <= 1'b0;
      if (hit_acc && !pending_q && hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
      if (miss_start && miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
      if (wb_done && wb_count != 32'hFFFF_FFFF) wb_count <= wb_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_set_assoc_dcache.sv
// Randomised and directed bench for set_assoc_dcache against a recency-list cache model.
module tb_set_assoc_dcache;
  localparam int ADDR_W = 32;
  localparam int WAYS   = 2;
  localparam int SETS   = 8;
  localparam int WORDS  = 4;
  localparam int TAG_W  = 25;
  localparam int MA_W   = 28;
  localparam int BLK_W  = 128;
  localparam int OP_W   = 1 + MA_W + BLK_W;

  logic       clock;
  logic       reset;
  logic [1:0] dbg_state;

  set_assoc_dcache_cpu_if #(.ADDR_W(ADDR_W)) cpu ();
  set_assoc_dcache_mem_if #(.MA_W(MA_W), .BLK_W(BLK_W)) mem ();

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count, miss_count, wb_count;
`endif

  set_assoc_dcache #(.ADDR_W(ADDR_W), .WAYS(WAYS), .SETS(SETS), .WORDS(WORDS)) dut (
    .clock(clock),
    .reset(reset),
    .cpu(cpu),
    .mem(mem),
    .dbg_state(dbg_state)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count(hit_count),
    .miss_count(miss_count),
    .wb_count(wb_count)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int lat      = 0;
  int stable_err = 0;
  int both_err   = 0;
  logic [OP_W-1:0] exp_q[$];
  logic [OP_W-1:0] obs_q[$];

  logic [BLK_W-1:0] env_mem [logic [MA_W-1:0]];
  logic [BLK_W-1:0] ref_mem [logic [MA_W-1:0]];

  bit               m_valid [WAYS][SETS];
  bit               m_dirty [WAYS][SETS];
  logic [TAG_W-1:0] m_tag   [WAYS][SETS];
  logic [BLK_W-1:0] m_data  [WAYS][SETS];
  int               rec     [SETS][WAYS];
  int m_hits, m_miss, m_wb;

  task automatic check_eq(input string tag, input logic [OP_W-1:0] got, input logic [OP_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [BLK_W-1:0] init_blk(input logic [MA_W-1:0] a);
    logic [BLK_W-1:0] b;
    for (int w = 0; w < WORDS; w++) b[w*32 +: 32] = {a[23:0], 8'(w)} ^ 32'h5A00_0000;
    return b;
  endfunction

  function automatic logic [BLK_W-1:0] env_get(input logic [MA_W-1:0] a);
    if (env_mem.exists(a)) return env_mem[a];
    return init_blk(a);
  endfunction

  function automatic logic [BLK_W-1:0] ref_get(input logic [MA_W-1:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_blk(a);
  endfunction

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) begin
        m_valid[w][s] = 1'b0;
        m_dirty[w][s] = 1'b0;
        rec[s][w] = w;
      end
    end
    m_hits = 0; m_miss = 0; m_wb = 0;
  endtask

  // rec[s] is the recency list of set s: element 0 most recent, last element least recent.
  task automatic touch(input int s, input int w);
    int p = 0;
    for (int i = 0; i < WAYS; i++) if (rec[s][i] == w) p = i;
    for (int i = p; i > 0; i--) rec[s][i] = rec[s][i-1];
    rec[s][0] = w;
  endtask

  task automatic model_access(input bit is_wr, input logic [31:0] addr, input logic [31:0] wd,
                              input bit drop, output bit hit, output int nops, output logic [31:0] rd);
    int s, o, way;
    logic [TAG_W-1:0] t;
    logic [MA_W-1:0] blk, vaddr;
    s = int'(addr[6:4]); o = int'(addr[3:2]); t = addr[31:7]; blk = addr[31:4];
    way = -1;
    for (int w = WAYS - 1; w >= 0; w--) if (m_valid[w][s] && m_tag[w][s] == t) way = w;
    hit = (way >= 0); nops = 0; rd = '0;
    if (!hit) begin
      m_miss++;
      way = rec[s][WAYS-1];
      for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[w][s]) way = w;
      if (m_valid[way][s] && m_dirty[way][s]) begin
        vaddr = {m_tag[way][s], 3'(s)};
        exp_q.push_back({1'b1, vaddr, m_data[way][s]});
        ref_mem[vaddr] = m_data[way][s];
        nops++; m_wb++;
      end
      exp_q.push_back({1'b0, blk, {BLK_W{1'b0}}});
      nops++;
      m_data[way][s] = ref_get(blk); m_tag[way][s] = t;
      m_valid[way][s] = 1'b1; m_dirty[way][s] = 1'b0;
      touch(s, way);
      if (drop) return;
    end else begin
      m_hits++;
    end
    if (is_wr) begin
      m_data[way][s][o*32 +: 32] = wd;
      m_dirty[way][s] = 1'b1;
    end else begin
      rd = m_data[way][s][o*32 +: 32];
    end
    touch(s, way);
  endtask

  // ---------------- memory responder / monitor ----------------
  initial begin
    int mem_cnt;
    logic [OP_W+1:0] held, cur;
    mem_cnt = 0; held = '0;
    mem.mem_busywait = 1'b0;
    mem.mem_readdata = '0;
    forever begin
      @(negedge clock);
      if (mem.mem_read || mem.mem_write) begin
        if (mem.mem_read && mem.mem_write) both_err++;
        cur = {mem.mem_read, mem.mem_write, mem.mem_address,
               mem.mem_write ? mem.mem_writedata : {BLK_W{1'b0}}};
        if (mem_cnt > 0 && cur != held) stable_err++;
        held = cur;
        if (mem_cnt < lat) begin
          mem.mem_busywait = 1'b1;
          mem_cnt++;
        end else begin
          mem.mem_busywait = 1'b0;
          mem_cnt = 0;
          obs_q.push_back({mem.mem_write, mem.mem_address,
                           mem.mem_write ? mem.mem_writedata : {BLK_W{1'b0}}});
          if (mem.mem_write) env_mem[mem.mem_address] = mem.mem_writedata;
          else               mem.mem_readdata = env_get(mem.mem_address);
        end
      end else begin
        mem.mem_busywait = 1'b0;
        mem_cnt = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic compare_ops(input string tag);
    check_eq({tag, "_nops"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) check_eq({tag, "_memop"}, obs_q.pop_front(), exp_q.pop_front());
    obs_q.delete();
    exp_q.delete();
  endtask

  // Called at a negedge; returns at a negedge with the request deasserted.
  task automatic access(input string tag, input bit is_wr, input logic [31:0] addr,
                        input logic [31:0] wd, input bit both, input bit drop);
    bit hit; int nops, stalls;
    logic [31:0] exp_rd;
    model_access(is_wr, addr, wd, drop, hit, nops, exp_rd);
    cpu.read = !is_wr || both; cpu.write = is_wr; cpu.address = addr; cpu.writedata = wd;
    #1;
    if (drop && !hit) begin
      check_eq({tag, "_busy"}, cpu.busywait, 1'b1);
      @(negedge clock);
      cpu.read = 1'b0; cpu.write = 1'b0;
      for (int i = 0; i < 200 && dbg_state != 2'd0; i++) @(negedge clock);
      check_eq({tag, "_idle"}, dbg_state, 2'd0);
      @(negedge clock);
    end else begin
      stalls = 0;
      while (cpu.busywait && stalls < 200) begin
        @(negedge clock); #1;
        stalls++;
      end
      check_eq({tag, "_stall"}, stalls, hit ? 0 : 1 + nops * (lat + 1));
      if (!is_wr) check_eq({tag, "_rdata"}, cpu.readdata, exp_rd);
      @(negedge clock);
      cpu.read = 1'b0; cpu.write = 1'b0;
    end
    compare_ops(tag);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] a;
    bit wr;
    reset = 1'b0;
    cpu.read = 1'b0; cpu.write = 1'b0; cpu.address = '0; cpu.writedata = '0;
    model_reset();
    env_mem[28'h4] = {32'h4444, 32'h3333, 32'h2222, 32'h1111};
    ref_mem[28'h4] = {32'h4444, 32'h3333, 32'h2222, 32'h1111};
    repeat (2) @(negedge clock);
    check_eq("rst_busy", cpu.busywait, 1'b0);
    check_eq("rst_rdata", cpu.readdata, 32'd0);
    check_eq("rst_mrd", mem.mem_read, 1'b0);
    check_eq("rst_mwr", mem.mem_write, 1'b0);
    check_eq("rst_state", dbg_state, 2'd0);
    reset = 1'b1;
    @(negedge clock);

    lat = 3;
    access("t1_rd40", 1'b0, 32'h40, 32'h0, 1'b0, 1'b0);
    lat = 1;
    access("t2_wr44", 1'b1, 32'h44, 32'hDEADBEEF, 1'b0, 1'b0);
    access("t2_rd44", 1'b0, 32'h44, 32'h0, 1'b0, 1'b0);
    access("t3_rd840", 1'b0, 32'h840, 32'h0, 1'b0, 1'b0);
    access("t3_rd840b", 1'b0, 32'h840, 32'h0, 1'b0, 1'b0);
    lat = 2;
    access("t3_rd1040", 1'b0, 32'h1040, 32'h0, 1'b0, 1'b0);
    access("t3_rd840c", 1'b0, 32'h840, 32'h0, 1'b0, 1'b0);
    lat = 5;
    access("t4_rd2050", 1'b0, 32'h2050, 32'h0, 1'b0, 1'b0);
    check_eq("t4_stable", stable_err, 0);

    lat = 6;
    cpu.read = 1'b1; cpu.address = 32'h3060;
    repeat (3) @(negedge clock);
    check_eq("t5_alloc", dbg_state, 2'd2);
    check_eq("t5_mrd_pre", mem.mem_read, 1'b1);
    reset = 1'b0;
    #1;
    check_eq("t5_mrd", mem.mem_read, 1'b0);
    check_eq("t5_busy", cpu.busywait, 1'b0);
    check_eq("t5_rdata", cpu.readdata, 32'd0);
    @(negedge clock);
    cpu.read = 1'b0; reset = 1'b1;
    model_reset();
    obs_q.delete(); exp_q.delete();
    @(negedge clock);
    lat = 2;
    access("t5_rd40", 1'b0, 32'h40, 32'h0, 1'b0, 1'b0);

    for (int n = 0; n < 300; n++) begin
      a = (32'($urandom_range(0, 3)) * 32'h0100_0080) | (32'($urandom_range(0, 7)) << 4)
        | 32'($urandom_range(0, 15));
      wr = ($urandom_range(0, 1) == 1);
      lat = $urandom_range(0, 3);
      access("rnd", wr, a, $urandom, $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
    end

    check_eq("stable", stable_err, 0);
    check_eq("both_req", both_err, 0);
`ifdef DCACHE_STATS_EN
    check_eq("hit_count", hit_count, m_hits);
    check_eq("miss_count", miss_count, m_miss);
    check_eq("wb_count", wb_count, m_wb);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
